// File: rtl/oup_sm_ulpi_syncmode_rx_pkg.sv
// Shared types for the ULPI synchronous-mode receive path: FSM states,
// RX CMD event encoding and the RX CMD byte layout.
package oup_sm_ulpi_syncmode_rx_p;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    IDLE      = 3'd1,
    TURN      = 3'd2,
    RECV      = 3'd3,
    REGR_TURN = 3'd4,
    REGR_DATA = 3'd5
  } rx_states_t;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ACTIVE   = 2'b01,
    HOSTDISC = 2'b10,
    ERROR    = 2'b11
  } rx_event_t;

  // Field order matches the RX CMD byte, MSB first.
  typedef struct packed {
    logic       alt_int;
    logic       id;
    rx_event_t  rx_event;
    logic [1:0] vbus_state;
    logic [1:0] linestate;
  } rxcmd_t;

endpackage

// File: rtl/oup_sm_ulpi_syncmode_rx_rxcmd_decode.sv
// Registers RX CMD status fields and tracks packet activity, error and
// end-of-packet from RX CMDs plus packet start/end hints from the FSM.
module oup_sm_ulpi_rxcmd_decode
  import oup_sm_ulpi_syncmode_rx_p::*;
#(
  parameter logic ID_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       cmd_valid,
  input  rxcmd_t     cmd,
  input  logic       pkt_start,
  input  logic       pkt_end,
  output logic [1:0] linestate,
  output logic [1:0] vbus_state,
  output logic       host_disconnect,
  output logic       id,
  output logic       alt_int,
  output logic       rx_active,
  output logic       rx_error,
  output logic       eop
);

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      linestate       <= 2'b00;
      vbus_state      <= 2'b00;
      host_disconnect <= 1'b0;
      id              <= ID_RESET;
      alt_int         <= 1'b0;
      rx_active       <= 1'b0;
      rx_error        <= 1'b0;
      eop             <= 1'b0;
    end else begin
      eop <= 1'b0;
      if (cmd_valid) begin
        linestate       <= cmd.linestate;
        vbus_state      <= cmd.vbus_state;
        host_disconnect <= (cmd.rx_event == HOSTDISC);
        id              <= cmd.id;
        alt_int         <= cmd.alt_int;
        rx_active       <= (cmd.rx_event != NONE);
        rx_error        <= rx_error | (cmd.rx_event == ERROR);
        eop             <= rx_active && (cmd.rx_event == NONE);
      end else if (pkt_start) begin
        rx_active <= 1'b1;
        rx_error  <= 1'b0;
      end else if (pkt_end) begin
        // Bus handed back mid-packet: close the packet here.
        rx_active <= 1'b0;
        eop       <= rx_active;
      end
    end
  end

endmodule

// File: rtl/oup_sm_ulpi_syncmode_rx.sv
// ULPI synchronous-mode receive FSM: bus ownership, turnaround, RX data
// and PHY register-read completion. Optional statistics: OUP_SM_ULPI_SYNCMODE_RX_STATS_EN.
module oup_sm_ulpi_syncmode_rx
  import oup_sm_ulpi_syncmode_rx_p::*;
#(
  parameter int   STATS_WIDTH = 16,
  parameter logic ID_RESET    = 1'b1
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic       rx_regr_assert_i,
  output logic       rx_done_o,
  output logic       rx_abort_o,
  output logic [7:0] phyreg_o,
  output logic [7:0] rx_data_o,
  output logic       rx_data_we_o,
  input  logic       rx_data_full_i,
  output logic       rx_overflow_o,
  input  logic       rx_overflow_clr_i,
  output logic       rx_eop_o,
  output logic       rx_active_o,
  output logic       rx_error_o,
  output logic [1:0] linestate_o,
  output logic [1:0] vbus_state_o,
  output logic       host_disconnect_o,
  output logic       id_o,
  output logic       alt_int_o
`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] rx_pkt_count_o,
  output logic [STATS_WIDTH-1:0] rx_err_count_o,
  output logic [STATS_WIDTH-1:0] rx_drop_count_o
`endif
);

  rx_states_t state_reg;
  logic       nxt_at_rise_reg;

  logic cmd_valid;
  logic pkt_start;
  logic pkt_end;
  logic data_byte;
  logic drop_byte;

  assign cmd_valid = (state_reg == RECV) && ulpi_dir_i && !ulpi_nxt_i;
  assign pkt_start = (state_reg == IDLE) && ulpi_dir_i && ulpi_nxt_i;
  assign pkt_end   = (state_reg == RECV) && !ulpi_dir_i;
  assign data_byte = (state_reg == RECV) && ulpi_dir_i && ulpi_nxt_i;
  assign drop_byte = data_byte && rx_data_full_i;

  always_ff @(posedge ulpi_clk_i) begin
    if (!rst_ni) begin
      state_reg       <= SYNC;
      nxt_at_rise_reg <= 1'b0;
      rx_done_o       <= 1'b0;
      rx_abort_o      <= 1'b0;
      phyreg_o        <= 8'h00;
      rx_data_o       <= 8'h00;
      rx_data_we_o    <= 1'b0;
      rx_overflow_o   <= 1'b0;
    end else begin
      rx_done_o    <= 1'b0;
      rx_abort_o   <= 1'b0;
      rx_data_we_o <= 1'b0;

      // A new drop in the same cycle as a clear keeps the flag set.
      if (rx_overflow_clr_i) rx_overflow_o <= 1'b0;
      if (drop_byte)         rx_overflow_o <= 1'b1;

      if (data_byte && !rx_data_full_i) begin
        rx_data_o    <= ulpi_data_i;
        rx_data_we_o <= 1'b1;
      end

      case (state_reg)
        SYNC: begin
          if (!ulpi_dir_i) state_reg <= IDLE;
        end
        IDLE: begin
          if (ulpi_dir_i) begin
            nxt_at_rise_reg <= ulpi_nxt_i;
            state_reg       <= rx_regr_assert_i ? REGR_TURN : TURN;
          end
        end
        TURN: begin
          state_reg <= ulpi_dir_i ? RECV : IDLE;
        end
        RECV: begin
          if (!ulpi_dir_i) state_reg <= IDLE;
        end
        REGR_TURN: begin
          if (nxt_at_rise_reg) begin
            // PHY started a USB receive instead of returning register data.
            rx_abort_o <= 1'b1;
            state_reg  <= RECV;
          end else if (!ulpi_dir_i) begin
            rx_abort_o <= 1'b1;
            state_reg  <= IDLE;
          end else begin
            state_reg <= REGR_DATA;
          end
        end
        REGR_DATA: begin
          phyreg_o  <= ulpi_data_i;
          rx_done_o <= 1'b1;
          state_reg <= RECV;
        end
        default: state_reg <= SYNC;
      endcase
    end
  end

  oup_sm_ulpi_rxcmd_decode #(
    .ID_RESET(ID_RESET)
  ) u_rxcmd_decode (
    .clk            (ulpi_clk_i),
    .rst_ni         (rst_ni),
    .cmd_valid      (cmd_valid),
    .cmd            (rxcmd_t'(ulpi_data_i)),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .linestate      (linestate_o),
    .vbus_state     (vbus_state_o),
    .host_disconnect(host_disconnect_o),
    .id             (id_o),
    .alt_int        (alt_int_o),
    .rx_active      (rx_active_o),
    .rx_error       (rx_error_o),
    .eop            (rx_eop_o)
  );

`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
  localparam logic [STATS_WIDTH-1:0] STATS_MAX = '1;

  always_ff @(posedge ulpi_clk_i) begin
    if (!rst_ni) begin
      rx_pkt_count_o  <= '0;
      rx_err_count_o  <= '0;
      rx_drop_count_o <= '0;
    end else begin
      if (rx_eop_o && rx_pkt_count_o != STATS_MAX)
        rx_pkt_count_o <= rx_pkt_count_o + 1'b1;
      if (rx_eop_o && rx_error_o && rx_err_count_o != STATS_MAX)
        rx_err_count_o <= rx_err_count_o + 1'b1;
      if (drop_byte && rx_drop_count_o != STATS_MAX)
        rx_drop_count_o <= rx_drop_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_oup_sm_ulpi_syncmode_rx.sv
// Directed bench for the ULPI sync-mode RX machine: reset/SYNC, RX CMD
// decode, USB data, register read, abort and FIFO overflow.
module tb_oup_sm_ulpi_syncmode_rx;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] data;
  logic       dir;
  logic       nxt;
  logic       regr;
  logic       rx_done, rx_abort, rx_we, full, ovf, ovf_clr, eop, active, err;
  logic       host_disc, id, alt_int;
  logic [7:0] phyreg, rx_data;
  logic [1:0] linestate, vbus;
`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
  logic [15:0] pkt_count, err_count, drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] wq[$];
  int eop_cnt   = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;

  always #5 clk = ~clk;

  oup_sm_ulpi_syncmode_rx #(
    .STATS_WIDTH(16),
    .ID_RESET   (1'b1)
  ) dut (
    .ulpi_clk_i       (clk),
    .rst_ni           (rst_ni),
    .ulpi_data_i      (data),
    .ulpi_dir_i       (dir),
    .ulpi_nxt_i       (nxt),
    .rx_regr_assert_i (regr),
    .rx_done_o        (rx_done),
    .rx_abort_o       (rx_abort),
    .phyreg_o         (phyreg),
    .rx_data_o        (rx_data),
    .rx_data_we_o     (rx_we),
    .rx_data_full_i   (full),
    .rx_overflow_o    (ovf),
    .rx_overflow_clr_i(ovf_clr),
    .rx_eop_o         (eop),
    .rx_active_o      (active),
    .rx_error_o       (err),
    .linestate_o      (linestate),
    .vbus_state_o     (vbus),
    .host_disconnect_o(host_disc),
    .id_o             (id),
    .alt_int_o        (alt_int)
`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
    ,
    .rx_pkt_count_o   (pkt_count),
    .rx_err_count_o   (err_count),
    .rx_drop_count_o  (drop_count)
`endif
  );

  // Collect pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (rx_we) wq.push_back(rx_data);
      if (eop) eop_cnt++;
      if (rx_done) done_cnt++;
      if (rx_abort) abort_cnt++;
      checks++;
      if (rx_done && rx_abort) begin
        failures++;
        $display("FAIL done_abort_overlap: done=%b abort=%b required not both 1", rx_done, rx_abort);
      end
    end
  end

  task automatic step(input logic d, input logic n, input logic [7:0] b);
    dir  = d;
    nxt  = n;
    data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; dir = 1'b1; nxt = 1'b1; data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({linestate, vbus, host_disc, alt_int, active, err, eop, rx_we, rx_done, rx_abort, ovf} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required all 0",
               {linestate, vbus, host_disc, alt_int, active, err, eop, rx_we, rx_done, rx_abort, ovf});
    end
    checks++;
    if ({phyreg, rx_data} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: phyreg=%h rx_data=%h required 00 00", phyreg, rx_data);
    end
    checks++;
    if (id !== 1'b1) begin
      failures++;
      $display("FAIL reset_id: got %b required 1", id);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i[0], 8'hFF);
      checks++;
      if (id !== 1'b1 || active !== 1'b0 || rx_we !== 1'b0 || linestate !== 2'b00) begin
        failures++;
        $display("FAIL sync_quiet[%0d]: id=%b active=%b we=%b ls=%b required 1 0 0 00",
                 i, id, active, rx_we, linestate);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (wq.size() != 0 || eop_cnt != 0 || id !== 1'b1) begin
      failures++;
      $display("FAIL sync_no_capture: writes=%0d eops=%0d id=%b required 0 0 1", wq.size(), eop_cnt, id);
    end
    $display("test_reset done");
  endtask

  task automatic test_rxcmd;
    int e0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h4D);
    checks++;
    if ({alt_int, id, host_disc, active, vbus, linestate} !== 8'b0100_1101) begin
      failures++;
      $display("FAIL rxcmd_4D: alt,id,hd,act,vbus,ls=%b required 01001101",
               {alt_int, id, host_disc, active, vbus, linestate});
    end
    step(1'b1, 1'b0, 8'hA2);
    checks++;
    if ({alt_int, id, host_disc, active, vbus, linestate} !== 8'b1011_0010) begin
      failures++;
      $display("FAIL rxcmd_A2: alt,id,hd,act,vbus,ls=%b required 10110010",
               {alt_int, id, host_disc, active, vbus, linestate});
    end
    e0 = eop_cnt;
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (eop !== 1'b1 || active !== 1'b0) begin
      failures++;
      $display("FAIL rxcmd_dirfall_eop: eop=%b active=%b required 1 0", eop, active);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (eop_cnt != e0 + 1) begin
      failures++;
      $display("FAIL rxcmd_eop_count: got %0d required %0d", eop_cnt - e0, 1);
    end
    $display("test_rxcmd done");
  endtask

  task automatic test_rx_packet;
    int e0;
    wq.delete();
    e0 = eop_cnt;
    step(1'b1, 1'b1, 8'h00);
    checks++;
    if (active !== 1'b1) begin
      failures++;
      $display("FAIL pkt_start_active: got %b required 1", active);
    end
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hA5);
    checks++;
    if (rx_we !== 1'b1 || rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL pkt_byte0: we=%b data=%h required 1 a5", rx_we, rx_data);
    end
    step(1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (eop !== 1'b1 || active !== 1'b0 || rx_we !== 1'b0) begin
      failures++;
      $display("FAIL pkt_end: eop=%b active=%b we=%b required 1 0 0", eop, active, rx_we);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (wq.size() != 2 || eop_cnt != e0 + 1) begin
      failures++;
      $display("FAIL pkt_counts: writes=%0d eops=%0d required 2 1", wq.size(), eop_cnt - e0);
    end else begin
      checks++;
      if (wq[0] !== 8'hA5 || wq[1] !== 8'hC3) begin
        failures++;
        $display("FAIL pkt_bytes: got %h %h required a5 c3", wq[0], wq[1]);
      end
    end
    $display("test_rx_packet done");
  endtask

  task automatic test_rx_error;
    int e0;
    wq.delete();
    e0 = eop_cnt;
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h30);
    checks++;
    if (err !== 1'b1 || active !== 1'b1) begin
      failures++;
      $display("FAIL err_rxcmd: err=%b active=%b required 1 1", err, active);
    end
    step(1'b1, 1'b0, 8'h00);
    checks++;
    if (eop !== 1'b1 || active !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_eop_by_rxcmd: eop=%b active=%b err=%b required 1 0 1", eop, active, err);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (eop !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_no_second_eop: eop=%b err=%b required 0 1", eop, err);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    checks++;
    if (err !== 1'b0 || active !== 1'b1) begin
      failures++;
      $display("FAIL err_clear_on_start: err=%b active=%b required 0 1", err, active);
    end
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (eop_cnt != e0 + 2 || wq.size() != 2) begin
      failures++;
      $display("FAIL err_counts: eops=%0d writes=%0d required 2 2", eop_cnt - e0, wq.size());
    end
    $display("test_rx_error done");
  endtask

  task automatic test_regr;
    int d0, a0, w0, e0;
    d0 = done_cnt; a0 = abort_cnt; w0 = wq.size(); e0 = eop_cnt;
    regr = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    checks++;
    if (rx_done !== 1'b0) begin
      failures++;
      $display("FAIL regr_done_early1: got %b required 0", rx_done);
    end
    step(1'b1, 1'b0, 8'hEE);
    checks++;
    if (rx_done !== 1'b0) begin
      failures++;
      $display("FAIL regr_done_early2: got %b required 0", rx_done);
    end
    step(1'b1, 1'b0, 8'h5A);
    checks++;
    if (rx_done !== 1'b1 || phyreg !== 8'h5A) begin
      failures++;
      $display("FAIL regr_capture: done=%b phyreg=%h required 1 5a", rx_done, phyreg);
    end
    regr = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (rx_done !== 1'b0 || phyreg !== 8'h5A) begin
      failures++;
      $display("FAIL regr_after: done=%b phyreg=%h required 0 5a", rx_done, phyreg);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (done_cnt != d0 + 1 || abort_cnt != a0 || wq.size() != w0 || eop_cnt != e0) begin
      failures++;
      $display("FAIL regr_counts: done=%0d abort=%0d writes=%0d eops=%0d required 1 0 0 0",
               done_cnt - d0, abort_cnt - a0, wq.size() - w0, eop_cnt - e0);
    end
    $display("test_regr done");
  endtask

  task automatic test_regr_abort;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    wq.delete();
    regr = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    checks++;
    if (rx_abort !== 1'b1 || rx_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse: abort=%b done=%b required 1 0", rx_abort, rx_done);
    end
    regr = 1'b0;
    step(1'b1, 1'b1, 8'h3C);
    checks++;
    if (rx_we !== 1'b1 || rx_data !== 8'h3C || rx_abort !== 1'b0) begin
      failures++;
      $display("FAIL abort_data: we=%b data=%h abort=%b required 1 3c 0", rx_we, rx_data, rx_abort);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (done_cnt != d0 || abort_cnt != a0 + 1 || wq.size() != 1) begin
      failures++;
      $display("FAIL abort_counts: done=%0d abort=%0d writes=%0d required 0 1 1",
               done_cnt - d0, abort_cnt - a0, wq.size());
    end
    $display("test_regr_abort done");
  endtask

  task automatic test_overflow;
    wq.delete();
    full = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hD1);
    checks++;
    if (ovf !== 1'b1 || rx_we !== 1'b0) begin
      failures++;
      $display("FAIL ovf_set: ovf=%b we=%b required 1 0", ovf, rx_we);
    end
    step(1'b1, 1'b1, 8'hD2);
    step(1'b1, 1'b1, 8'hD3);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (ovf !== 1'b1 || wq.size() != 0) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b writes=%0d required 1 0", ovf, wq.size());
    end
`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
    checks++;
    if (drop_count !== 16'd3) begin
      failures++;
      $display("FAIL stats_drop3: got %0d required 3", drop_count);
    end
`endif
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    ovf_clr = 1'b1;
    step(1'b1, 1'b1, 8'hE1);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b required 1", ovf);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b required 0", ovf);
    end
    ovf_clr = 1'b0;
    full    = 1'b0;
    step(1'b0, 1'b0, 8'h00);
`ifdef OUP_SM_ULPI_SYNCMODE_RX_STATS_EN
    checks++;
    if (drop_count !== 16'd4 || pkt_count !== 16'd7 || err_count !== 16'd1) begin
      failures++;
      $display("FAIL stats_final: drop=%0d pkt=%0d err=%0d required 4 7 1",
               drop_count, pkt_count, err_count);
    end
`endif
    $display("test_overflow done");
  endtask

  initial begin
    rst_ni  = 1'b0;
    dir     = 1'b1;
    nxt     = 1'b0;
    data    = 8'h00;
    regr    = 1'b0;
    full    = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_rxcmd();
    test_rx_packet();
    test_rx_error();
    test_regr();
    test_regr_abort();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
